// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared FSM states, opcodes and ALU operation codes
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_ADDR   = 4'd3,
        S_MEM_RD = 4'd4,
        S_MEM_WR = 4'd5,
        S_WB_R   = 4'd6,
        S_WB_MEM = 4'd7,
        S_BRANCH = 4'd8
    } state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1010;
    localparam logic [3:0] OP_BNE = 4'b1110;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    // Register-register arithmetic/logic opcodes share the EXEC_R/WB_R path.
    function automatic logic is_rtype(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - maps a latched R-type opcode to its ALU operation code
module alu_op_decode
    import multicycle_control_pkg::*;
(
    input  logic [3:0] op_q,
    output logic [2:0] alu_op
);

    // Opcodes that never reach EXEC_R fall back to AND; the value is unused there.
    always_comb begin
        alu_op = ALU_AND;
        case (op_q)
            OP_AND:  alu_op = ALU_AND;
            OP_OR:   alu_op = ALU_OR;
            OP_ADD:  alu_op = ALU_ADD;
            OP_SUB:  alu_op = ALU_SUB;
            OP_SLT:  alu_op = ALU_SLT;
            default: alu_op = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle processor control FSM
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PC_write,
    output logic       IR_write,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALU_src,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       MemToReg,
    output logic       branch,
    output logic       PC_src,
    output logic [2:0] ALU_op,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [2:0] r_alu_op;

    alu_op_decode u_alu_op_decode (
        .op_q   (op_q),
        .alu_op (r_alu_op)
    );

    assign state = state_q;

    // State and latched opcode registers; reset returns to FETCH with a cleared opcode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= OP_AND;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state and control decode; reset forces every control output low.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        PC_write   = 1'b0;
        IR_write   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALU_src    = 1'b0;
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
        MemToReg   = 1'b0;
        branch     = 1'b0;
        PC_src     = 1'b0;
        ALU_op     = ALU_AND;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALU_op  = ALU_ADD;
                if (mem_ready) begin
                    IR_write = 1'b1;
                    PC_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (is_rtype(opcode)) begin
                    state_d = S_EXEC_R;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_ADDR;
                end else if (opcode == OP_BNE) begin
                    state_d = S_BRANCH;
                end else begin
                    illegal_op = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXEC_R: begin
                RegDst  = 1'b1;
                ALU_op  = r_alu_op;
                state_d = S_WB_R;
            end
            S_WB_R: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDR: begin
                ALU_src = 1'b1;
                ALU_op  = ALU_ADD;
                if (op_q == OP_LW) begin
                    state_d = S_MEM_RD;
                end else if (op_q == OP_SW) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    state_d = S_WB_MEM;
                end
            end
            S_WB_MEM: begin
                RegWrite   = 1'b1;
                MemToReg   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                ALU_src  = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_BRANCH: begin
                branch     = 1'b1;
                ALU_op     = ALU_SUB;
                instr_done = 1'b1;
                if (!zero) begin
                    PC_src   = 1'b1;
                    PC_write = 1'b1;
                end
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (rst) begin
            PC_write   = 1'b0;
            IR_write   = 1'b0;
            RegDst     = 1'b0;
            RegWrite   = 1'b0;
            ALU_src    = 1'b0;
            MemWrite   = 1'b0;
            MemRead    = 1'b0;
            MemToReg   = 1'b0;
            branch     = 1'b0;
            PC_src     = 1'b0;
            ALU_op     = ALU_AND;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - cycle-accurate plan-based check of multicycle_control
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic       clk = 1'b0;
    logic       rst, zero, mem_ready;
    logic [3:0] opcode;
    logic       PC_write, IR_write, RegDst, RegWrite, ALU_src, MemWrite, MemRead;
    logic       MemToReg, branch, PC_src, instr_done, illegal_op;
    logic [2:0] ALU_op;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PC_write   (PC_write),
        .IR_write   (IR_write),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .ALU_src    (ALU_src),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .MemToReg   (MemToReg),
        .branch     (branch),
        .PC_src     (PC_src),
        .ALU_op     (ALU_op),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .state      (state)
    );

    typedef struct packed {
        logic       pc_write, ir_write, reg_dst, reg_write, alu_src;
        logic       mem_write, mem_read, mem_to_reg, branch, pc_src;
        logic [2:0] alu_op;
        logic       done, illegal;
        logic [3:0] st;
    } vec_t;

    typedef struct {
        logic       rst;
        logic [3:0] opcode;
        logic       zero;
        logic       mem_ready;
        vec_t       exp;
        string      tag;
    } cyc_t;

    cyc_t plan[$];
    int   issued     = 0;
    int   compared   = 0;
    int   mismatched = 0;
    int   dones      = 0;

    function automatic vec_t base(input state_t s);
        vec_t v;
        v    = '0;
        v.st = s;
        return v;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // ALU code each R-type opcode must select, from the opcode/ALU tables.
    function automatic logic [2:0] alu_for(input logic [3:0] op);
        case (op)
            4'b0000: return 3'b000;
            4'b0001: return 3'b001;
            4'b0010: return 3'b010;
            4'b0110: return 3'b011;
            4'b0111: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic push(input vec_t v, input logic r, input logic [3:0] op,
                        input logic z, input logic mr, input string tag);
        cyc_t c;
        c.rst = r; c.opcode = op; c.zero = z; c.mem_ready = mr; c.exp = v; c.tag = tag;
        plan.push_back(c);
    endtask

    task automatic check(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // One instruction: fwait/mwait idle memory cycles; abort stops inside the MEM_WR wait.
    task automatic add_instr(input logic [3:0] op, input logic z, input int fwait,
                             input int mwait, input bit abort = 0);
        vec_t v;
        for (int i = 0; i < fwait; i++) begin
            v = base(S_FETCH); v.mem_read = 1; v.alu_op = 3'b010;
            push(v, 0, 4'($urandom), rbit(), 0, "fetch_wait");
        end
        v = base(S_FETCH); v.mem_read = 1; v.alu_op = 3'b010; v.ir_write = 1; v.pc_write = 1;
        push(v, 0, 4'($urandom), rbit(), 1, "fetch");
        v = base(S_DECODE);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b1010, 4'b1110: ;
            default: begin
                v.illegal = 1;
                push(v, 0, op, rbit(), rbit(), "decode_illegal");
                return;
            end
        endcase
        push(v, 0, op, rbit(), rbit(), "decode");
        if (op == 4'b1000 || op == 4'b1010) begin
            v = base(S_ADDR); v.alu_src = 1; v.alu_op = 3'b010;
            push(v, 0, op, rbit(), rbit(), "addr");
            for (int i = 0; i < mwait; i++) begin
                if (op == 4'b1000) begin
                    v = base(S_MEM_RD); v.mem_read = 1;
                end else begin
                    v = base(S_MEM_WR); v.mem_write = 1; v.alu_src = 1;
                end
                push(v, 0, op, rbit(), 0, "mem_wait");
            end
            if (abort) return;
            if (op == 4'b1000) begin
                v = base(S_MEM_RD); v.mem_read = 1;
                push(v, 0, op, rbit(), 1, "mem_rd");
                v = base(S_WB_MEM); v.reg_write = 1; v.mem_to_reg = 1; v.done = 1;
                push(v, 0, op, rbit(), rbit(), "wb_mem");
            end else begin
                v = base(S_MEM_WR); v.mem_write = 1; v.alu_src = 1; v.done = 1;
                push(v, 0, op, rbit(), 1, "mem_wr");
            end
        end else if (op == 4'b1110) begin
            v = base(S_BRANCH); v.branch = 1; v.alu_op = 3'b011; v.done = 1;
            if (!z) begin v.pc_src = 1; v.pc_write = 1; end
            push(v, 0, op, z, rbit(), "branch");
        end else begin
            v = base(S_EXEC_R); v.reg_dst = 1; v.alu_op = alu_for(op);
            push(v, 0, op, rbit(), rbit(), "exec_r");
            v = base(S_WB_R); v.reg_write = 1; v.reg_dst = 1; v.done = 1;
            push(v, 0, op, rbit(), rbit(), "wb_r");
        end
        issued++;
    endtask

    // A reset cycle: controls low, state still shows where the previous edge left it.
    task automatic add_reset(input state_t seen, input logic mr);
        push(base(seen), 1, 4'($urandom), rbit(), mr, "reset");
    endtask

    logic [3:0] legal[8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                             4'b0111, 4'b1000, 4'b1010, 4'b1110};

    initial begin
        int   n;
        vec_t act;
        rst = 1; opcode = 0; zero = 0; mem_ready = 0;

        add_reset(S_FETCH, 1);
        add_reset(S_FETCH, 0);
        n = plan.size(); add_instr(4'b0010, 0, 0, 0); check("lat_add", plan.size() - n, 4);
        n = plan.size(); add_instr(4'b1000, 0, 0, 2); check("lat_lw_wait2", plan.size() - n, 7);
        n = plan.size(); add_instr(4'b1000, 0, 0, 0); check("lat_lw", plan.size() - n, 5);
        n = plan.size(); add_instr(4'b1010, 0, 0, 0); check("lat_sw", plan.size() - n, 4);
        n = plan.size(); add_instr(4'b1110, 0, 0, 0); check("lat_bne_z0", plan.size() - n, 3);
        n = plan.size(); add_instr(4'b1110, 1, 0, 0); check("lat_bne_z1", plan.size() - n, 3);
        n = plan.size(); add_instr(4'b0011, 0, 0, 0); check("lat_illegal", plan.size() - n, 2);
        n = plan.size(); add_instr(4'b0110, 0, 2, 0); check("lat_sub_fwait2", plan.size() - n, 6);
        add_instr(4'b0000, 0, 1, 0);
        add_instr(4'b0001, 0, 0, 0);
        add_instr(4'b0111, 0, 0, 0);
        add_instr(4'b1111, 0, 1, 0);
        add_instr(4'b1010, 0, 0, 2);
        add_instr(4'b1010, 0, 0, 1, 1);
        add_reset(S_MEM_WR, 0);
        add_instr(4'b1000, 0, 0, 1, 1);
        add_reset(S_MEM_RD, 1);
        add_reset(S_FETCH, 0);
        for (int k = 0; k < 30; k++)
            add_instr(legal[$urandom_range(0, 7)], rbit(), $urandom_range(0, 2), $urandom_range(0, 2));
        begin
            vec_t v;
            v = base(S_FETCH); v.mem_read = 1; v.alu_op = 3'b010;
            push(v, 0, 4'b0000, 0, 0, "tail");
        end

        foreach (plan[i]) begin
            @(posedge clk);
            #1;
            rst = plan[i].rst; opcode = plan[i].opcode;
            zero = plan[i].zero; mem_ready = plan[i].mem_ready;
            @(negedge clk);
            act = {PC_write, IR_write, RegDst, RegWrite, ALU_src, MemWrite, MemRead,
                   MemToReg, branch, PC_src, ALU_op, instr_done, illegal_op, state};
            compared++;
            if (act !== plan[i].exp) begin
                mismatched++;
                $display("FAIL cycle %0d %s: got %05h expected %05h", i, plan[i].tag,
                         act, plan[i].exp);
            end
            compared++;
            if ((MemRead && MemWrite) || (RegWrite && MemWrite)) begin
                mismatched++;
                $display("FAIL cycle %0d exclusive_mem: got MemRead=%b RegWrite=%b MemWrite=%b expected no overlap",
                         i, MemRead, RegWrite, MemWrite);
            end
            if (instr_done === 1'b1) dones++;
        end
        check("instr_done_count", dones, issued);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; opcode width fixed at 4 bits, ALU_op width fixed at 3 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 opcode  input  4  instruction opcode from IR, valid from DECODE onward.
REQ-005 zero  input  1  ALU zero flag, sampled in BRANCH.
REQ-006 mem_ready  input  1  memory handshake; access completes in the cycle it is high.
REQ-007 PC_write, IR_write  output  1 each  PC update enable; instruction-register load enable.
REQ-008 RegDst, RegWrite, ALU_src, MemWrite, MemRead, MemToReg, branch, PC_src  output  1 each  datapath controls, same meaning as the single-cycle decoder.
REQ-009 ALU_op  output  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT.
REQ-010 instr_done  output  1  one-cycle pulse when an instruction retires.
REQ-011 illegal_op  output  1  one-cycle pulse on an unrecognised opcode.
REQ-012 state  output  4  current FSM state, for debug.

Function
REQ-013 States: FETCH, DECODE, EXEC_R, ADDR, MEM_RD, MEM_WR, WB_R, WB_MEM, BRANCH.
REQ-014 FETCH: MemRead=1, ALU_src=0, ALU_op=ADD (PC+1); hold while mem_ready=0; when mem_ready=1: IR_write=1, PC_write=1, next DECODE.
REQ-015 DECODE: latch opcode into op_q; AND/OR/ADD/SUB/SLT (0000/0001/0010/0110/0111) -> EXEC_R; LW 1000 / SW 1010 -> ADDR; BNE 1110 -> BRANCH; any other opcode -> FETCH with illegal_op=1 and no datapath write.
REQ-016 EXEC_R: RegDst=1, ALU_src=0, ALU_op from op_q per REQ-009; next WB_R.
REQ-017 WB_R: RegWrite=1, RegDst=1, MemToReg=0, instr_done=1; next FETCH.
REQ-018 ADDR: ALU_src=1, ALU_op=ADD; next MEM_RD if op_q=LW, MEM_WR if op_q=SW.
REQ-019 MEM_RD: MemRead=1; hold until mem_ready=1, then WB_MEM.
REQ-020 WB_MEM: RegWrite=1, RegDst=0, MemToReg=1, instr_done=1; next FETCH.
REQ-021 MEM_WR: MemWrite=1, ALU_src=1; hold until mem_ready=1; then instr_done=1, next FETCH.
REQ-022 BRANCH: branch=1, ALU_src=0, ALU_op=SUB; if zero=0: PC_src=1, PC_write=1; instr_done=1 either way; next FETCH.
REQ-023 Outputs not listed for a state SHALL be 0; outputs are a function of state, op_q, zero and mem_ready only.
REQ-024 MemRead and MemWrite SHALL never be high together; RegWrite and MemWrite SHALL never be high together.
REQ-025 Latency with mem_ready tied high: R-type 4 cycles, LW 5, SW 4, BNE 3, illegal 2 (FETCH+DECODE).
REQ-026 Each cycle mem_ready=0 in FETCH/MEM_RD/MEM_WR adds exactly one cycle; the asserted controls stay stable while waiting.
REQ-027 mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.

Reset
REQ-028 rst=1 at a clock edge SHALL force state=FETCH and op_q=0000, including mid-instruction and mid-wait; rst overrides all other inputs.
REQ-029 While rst is high, all control outputs, instr_done and illegal_op SHALL be 0; the first FETCH drive follows the first edge with rst=0.

Structure
REQ-030 A shared package SHALL hold the state enum, the opcode constants (AND, OR, ADD, SUB, SLT, LW, SW, BNE) and the ALU_op constants; the package is also used by the single-cycle decoder and the ALU.
REQ-031 One sub-module, alu_op_decode (op_q -> ALU_op), is natural; the FSM register and output decode stay in multicycle_control.

Verification
REQ-032 ADD 0010, mem_ready=1 -> states FETCH,DECODE,EXEC_R,WB_R; RegWrite=1 only in cycle 4; ALU_op=010 in EXEC_R; instr_done pulses once.
REQ-033 LW 1000, mem_ready low 2 cycles in MEM_RD -> MEM_RD held 3 cycles with MemRead=1; then WB_MEM with MemToReg=1, RegDst=0; total 7 cycles.
REQ-034 BNE 1110 with zero=0 -> PC_src=1, PC_write=1 in BRANCH; with zero=1 -> PC_src=0, PC_write=0; both retire in 3 cycles.
REQ-035 opcode 0011 -> illegal_op pulse in DECODE, no RegWrite/MemWrite, back to FETCH after 2 cycles.
REQ-036 SW 1010, rst asserted during MEM_WR wait -> next edge state=FETCH, MemWrite=0, no instr_done.
REQ-037 Back-to-back random legal stream -> MemRead/MemWrite and RegWrite/MemWrite never high together; instr_done count equals instructions issued.
